// File: rtl/riscv_pkg.sv
// Shared RISC-V decode definitions: immediate format selector encoding and the
// occupancy states of the registered immediate stage.
package riscv_pkg;

  localparam int IMM_SRC_W = 3;
  localparam int INSTR_W   = 32;

  typedef enum logic [IMM_SRC_W-1:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4
  } imm_src_e;

  // Encoded as {main_vld, skid_vld}; 2'b01 (skid without main) is unreachable.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b10,
    ST_SKID  = 2'b11
  } pipe_state_e;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Stream bundle for the immediate stage: upstream instr/imm_src/tag with
// valid/ready, downstream imm/illegal/tag with valid/ready.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  import riscv_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [INSTR_W-1:0]   instr;
  logic [IMM_SRC_W-1:0] imm_src;
  logic [TAG_W-1:0]     in_tag;

  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      out_imm;
  logic                 out_illegal;
  logic [TAG_W-1:0]     out_tag;

  // master: decode front-end plus execute-side consumer; slave: the stage itself
  modport master (
    output in_valid, instr, imm_src, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_illegal, out_tag
  );

  modport slave (
    input  in_valid, instr, imm_src, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_illegal, out_tag
  );

endinterface

// File: rtl/imm_decode.sv
// Combinational RISC-V immediate extractor for the I/S/B/J/U formats,
// sign-extended from instr[31] to XLEN; unknown selectors give zero and a flag.
module imm_decode
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [INSTR_W-1:0]   i_instr,
  input  logic [IMM_SRC_W-1:0] i_imm_src,
  output logic [XLEN-1:0]      o_imm,
  output logic                 o_illegal
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_decode: XLEN must be 32 or 64");
  end

  logic [31:0] w_imm32;

  // NOTE: every output of this block is given a default first so no path
  // through the case leaves a signal unassigned (which would infer a latch).
  always_comb begin
    w_imm32   = '0;
    o_illegal = 1'b0;
    case (i_imm_src)
      IMM_I:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
      IMM_S:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      IMM_B:   w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                          i_instr[30:25], i_instr[11:8], 1'b0};
      IMM_J:   w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                          i_instr[20], i_instr[30:21], 1'b0};
      IMM_U:   w_imm32 = {i_instr[31:12], 12'b0};
      default: o_illegal = 1'b1;
    endcase
  end

  // Bit 31 of every format is instr[31], so one sign extension covers XLEN=64.
  assign o_imm = XLEN'(signed'(w_imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate stage with a one-entry skid buffer: decodes on accept,
// presents the result one cycle later and never drops a transaction under stall.
module imm_gen_pipe
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input logic           clk,
  input logic           rst_n,
  imm_gen_pipe_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  pipe_state_e r_state;
  pipe_state_e w_state_nxt;
  entry_t      r_main;
  entry_t      r_skid;
  entry_t      w_new;

  logic [XLEN-1:0] w_dec_imm;
  logic            w_dec_illegal;
  logic            w_main_vld;
  logic            w_skid_vld;
  logic            w_in_ready;
  logic            w_in_fire;
  logic            w_load_main_new;
  logic            w_load_main_skid;
  logic            w_load_skid;

  imm_decode #(.XLEN(XLEN)) u_imm_decode (
    .i_instr   (bus.instr),
    .i_imm_src (bus.imm_src),
    .o_imm     (w_dec_imm),
    .o_illegal (w_dec_illegal)
  );

  assign w_new = '{imm: w_dec_imm, illegal: w_dec_illegal, tag: bus.in_tag};

  assign w_main_vld = r_state[1];
  assign w_skid_vld = r_state[0];
  // Ready depends only on registered state, never on out_ready.
  assign w_in_ready = rst_n & ~w_skid_vld;
  assign w_in_fire  = bus.in_valid & w_in_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_new  = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_state_nxt     = ST_FULL;
          w_load_main_new = 1'b1;
        end
      end
      ST_FULL: begin
        if (w_in_fire && bus.out_ready) begin
          w_load_main_new = 1'b1;
        end else if (w_in_fire) begin
          w_state_nxt = ST_SKID;
          w_load_skid = 1'b1;
        end else if (bus.out_ready) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_SKID: begin
        if (bus.out_ready) begin
          w_state_nxt      = ST_FULL;
          w_load_main_skid = 1'b1;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // NOTE: state and data registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: the data registers are reset too, because the output bus must read
  // zero after reset and a stale skid entry must never resurface.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main_new) begin
        r_main <= w_new;
      end else if (w_load_main_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_new;
      end
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = w_main_vld;
  assign bus.out_imm     = r_main.imm;
  assign bus.out_illegal = r_main.illegal;
  assign bus.out_tag     = r_main.tag;

  a_skid_implies_main : assert property (
    @(posedge clk) disable iff (!rst_n) (w_skid_vld -> w_main_vld)
  );

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed and randomised checks of imm_gen_pipe at XLEN=32 and XLEN=64.
module tb_imm_gen_pipe;
  import riscv_pkg::*;

  localparam int N_RAND     = 10000;
  localparam int RAND_LIMIT = 60000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) bus32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(8))  bus64 ();

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
  imm_gen_pipe #(.XLEN(64), .TAG_W(8))  u_dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive32(input logic [31:0] ins, input logic [2:0] src, input logic [31:0] tag);
    bus32.in_valid = 1'b1;
    bus32.instr    = ins;
    bus32.imm_src  = src;
    bus32.in_tag   = tag;
  endtask

  function automatic logic [31:0] ref_imm(input logic [31:0] ins, input logic [2:0] src);
    logic [31:0] r;
    r = '0;
    if (src == 3'd0) r = {{20{ins[31]}}, ins[31:20]};
    if (src == 3'd1) r = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    if (src == 3'd2) r = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    if (src == 3'd3) r = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    if (src == 3'd4) r = {ins[31:12], 12'b0};
    return r;
  endfunction

  logic [31:0] v_instr [5] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h0010006F, 32'h800002B7};
  logic [2:0]  v_src   [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
  logic [31:0] v_exp   [5] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h00000800, 32'h80000000};

  logic [64:0] q[$];
  logic [64:0] held;
  logic [64:0] got;
  logic        stall_prev;
  logic        in_fire;
  logic        out_fire;
  int          sent;
  int          recv;
  int          cycles;

  initial begin
    bus32.in_valid = 1'b0; bus32.instr = '0; bus32.imm_src = '0; bus32.in_tag = '0;
    bus32.out_ready = 1'b1;
    bus64.in_valid = 1'b0; bus64.instr = '0; bus64.imm_src = '0; bus64.in_tag = '0;
    bus64.out_ready = 1'b1;

    // Reset state
    tick(); tick();
    check("rst_in_ready", bus32.in_ready, 1'b0);
    check("rst_out_valid", bus32.out_valid, 1'b0);
    check("rst_out_imm", bus32.out_imm, 32'h0);
    check("rst_out_illegal", bus32.out_illegal, 1'b0);
    check("rst_out_tag", bus32.out_tag, 32'h0);
    rst_n = 1'b1;
    #1;
    check("rst_release_in_ready", bus32.in_ready, 1'b1);

    // 1: back-to-back formats, one result per cycle, one cycle after accept
    for (int i = 0; i < 5; i++) begin
      drive32(v_instr[i], v_src[i], 32'(i + 1));
      tick();
      check($sformatf("fmt%0d_valid", i), bus32.out_valid, 1'b1);
      check($sformatf("fmt%0d_imm", i), bus32.out_imm, v_exp[i]);
      check($sformatf("fmt%0d_tag", i), bus32.out_tag, 32'(i + 1));
      check($sformatf("fmt%0d_in_ready", i), bus32.in_ready, 1'b1);
    end
    bus32.in_valid = 1'b0;
    tick();
    check("fmt_drained", bus32.out_valid, 1'b0);

    // 2: XLEN=64 sign extension
    bus64.in_valid = 1'b1; bus64.instr = 32'h800002B7; bus64.imm_src = 3'd4; bus64.in_tag = 8'hA1;
    tick();
    check("x64_u_imm", bus64.out_imm, 64'hFFFFFFFF80000000);
    check("x64_u_tag", bus64.out_tag, 8'hA1);
    bus64.instr = 32'hFFF00093; bus64.imm_src = 3'd0; bus64.in_tag = 8'hA2;
    tick();
    check("x64_i_imm", bus64.out_imm, 64'hFFFFFFFFFFFFFFFF);
    check("x64_i_tag", bus64.out_tag, 8'hA2);
    bus64.in_valid = 1'b0;
    tick();
    check("x64_drained", bus64.out_valid, 1'b0);

    // 3: back-pressure with three offered inputs
    bus32.out_ready = 1'b0;
    drive32(32'h00100093, 3'd0, 32'd1);
    tick();
    check("bp_a_in_ready", bus32.in_ready, 1'b1);
    check("bp_a_tag", bus32.out_tag, 32'd1);
    drive32(32'h00200093, 3'd0, 32'd2);
    tick();
    check("bp_b_in_ready", bus32.in_ready, 1'b0);
    check("bp_b_imm_held", bus32.out_imm, 32'd1);
    drive32(32'h00300093, 3'd0, 32'd3);
    tick();
    check("bp_c_in_ready", bus32.in_ready, 1'b0);
    check("bp_c_tag_held", bus32.out_tag, 32'd1);
    bus32.out_ready = 1'b1;
    tick();
    check("bp_d_tag", bus32.out_tag, 32'd2);
    check("bp_d_imm", bus32.out_imm, 32'd2);
    check("bp_d_in_ready", bus32.in_ready, 1'b1);
    tick();
    check("bp_e_tag", bus32.out_tag, 32'd3);
    check("bp_e_imm", bus32.out_imm, 32'd3);
    bus32.in_valid = 1'b0;
    tick();
    check("bp_f_drained", bus32.out_valid, 1'b0);

    // 4: illegal selector is a normal transaction
    drive32(32'hFFFFFFFF, 3'd7, 32'h55);
    tick();
    check("ill_valid", bus32.out_valid, 1'b1);
    check("ill_imm", bus32.out_imm, 32'h0);
    check("ill_flag", bus32.out_illegal, 1'b1);
    check("ill_tag", bus32.out_tag, 32'h55);
    drive32(32'h00100093, 3'd0, 32'h56);
    tick();
    check("ill_clear_flag", bus32.out_illegal, 1'b0);
    check("ill_clear_imm", bus32.out_imm, 32'h1);
    bus32.in_valid = 1'b0;
    tick();

    // 5: reset while both entries are occupied
    bus32.out_ready = 1'b0;
    drive32(32'h80000037, 3'd4, 32'h10);
    tick();
    drive32(32'hFFF00093, 3'd0, 32'h11);
    tick();
    check("rst5_skid_in_ready", bus32.in_ready, 1'b0);
    bus32.in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    check("rst5_out_valid", bus32.out_valid, 1'b0);
    check("rst5_out_imm", bus32.out_imm, 32'h0);
    check("rst5_out_tag", bus32.out_tag, 32'h0);
    check("rst5_in_ready", bus32.in_ready, 1'b0);
    rst_n = 1'b1;
    #1;
    check("rst5_release_in_ready", bus32.in_ready, 1'b1);
    bus32.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst5_no_stale%0d", i), bus32.out_valid, 1'b0);
    end

    // 6: random valid/ready against a reference queue
    sent = 0; recv = 0; cycles = 0; stall_prev = 1'b0; held = '0;
    while (recv < N_RAND && cycles < RAND_LIMIT) begin
      got = {bus32.out_illegal, bus32.out_imm, bus32.out_tag};
      if (stall_prev) check("rand_hold", got, held);
      if (!bus32.in_valid && sent < N_RAND && $urandom_range(0, 4) != 0) begin
        drive32($urandom, 3'($urandom_range(0, 7)), 32'(sent));
      end
      bus32.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      in_fire  = bus32.in_valid & bus32.in_ready;
      out_fire = bus32.out_valid & bus32.out_ready;
      if (out_fire) begin
        check("rand_queue_nonempty", (q.size() != 0), 1'b1);
        if (q.size() != 0) begin
          check("rand_out", got, q.pop_front());
          recv++;
        end
      end
      if (in_fire) begin
        q.push_back({(bus32.imm_src > 3'd4), ref_imm(bus32.instr, bus32.imm_src), bus32.in_tag});
        sent++;
      end
      stall_prev = bus32.out_valid & ~bus32.out_ready;
      held = got;
      tick();
      cycles++;
      if (in_fire) bus32.in_valid = 1'b0;
    end
    check("rand_all_received", recv, N_RAND);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
